uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte FIFO plus sequencer that sits directly upstream of the UART transmitter core.
//  Buffers bytes from a producer (test pattern generator, command logic).
//  Drains them one at a time into the core's i_data/i_we inputs, honouring o_busy.
//  Replaces the fixed single-byte driver, so multi-byte messages go out back-to-back.
// PARAMETERS
//  AW       4   FIFO address width; depth = 2**AW entries (16).
//  W        8   Data width; must match the UART core's L.
//  ACK_TO   15  Max cycles to wait for i_uart_busy to rise after a write strobe.
// PORTS
//  i_clk        in   1     system clock
//  i_rst        in   1     reset, asynchronous, active-high
//  i_wr_en      in   1     producer write strobe; one byte per cycle high
//  i_wr_data    in   W     producer byte
//  o_full       out  1     FIFO holds 2**AW entries (registered)
//  o_empty      out  1     FIFO holds 0 entries (registered)
//  o_count      out  AW+1  current occupancy
//  o_overflow   out  1     sticky: a write was dropped because o_full=1
//  o_ack_err    out  1     sticky: core never raised busy within ACK_TO cycles
//  o_uart_data  out  W     byte to core i_data; held stable from strobe until busy falls
//  o_uart_we    out  1     single-cycle write strobe to core i_we
//  i_uart_busy  in   1     core o_busy
// BEHAVIOUR
//  Reset (async): count=0, rd/wr pointers=0, o_empty=1, o_full=0, o_overflow=0, o_ack_err=0.
//   Also on reset: o_uart_we=0, o_uart_data=0, FSM=IDLE, timeout counter=0.
//   Reset mid-transfer discards all FIFO contents; the core is reset by the same i_rst.
//  FIFO write: i_wr_en=1 and o_full=0 at edge -> store byte, wr_ptr+1 mod 2**AW.
//   i_wr_en=1 and o_full=1 -> byte dropped, o_overflow<=1, cleared only by reset.
//   o_full is registered: a write during a same-cycle pop while full is still dropped.
//  Simultaneous accepted write and pop: count unchanged, both pointers advance.
//  Pointers wrap modulo 2**AW; o_count = wr-rd occupancy, range 0..2**AW.
//  FSM states:
//   IDLE    : if !o_empty && !i_uart_busy -> pop head into o_uart_data, o_uart_we<=1, ->STROBE.
//   STROBE  : o_uart_we<=0 (strobe is exactly 1 cycle), clear timer, ->WAIT_HI.
//   WAIT_HI : if i_uart_busy -> WAIT_LO;
//             else timer+1; timer==ACK_TO -> o_ack_err<=1, ->IDLE (byte lost).
//   WAIT_LO : if !i_uart_busy -> IDLE.
//  Latency: byte written at edge N into an empty FIFO with the core idle.
//   o_uart_we is high in the cycle after edge N+1; pop happens at that same edge N+1.
//  Throughput: next strobe no earlier than 1 cycle after busy falls (IDLE re-check).
//  o_uart_data changes only on a pop; it is held through WAIT_HI/WAIT_LO.
//  i_uart_busy high while in IDLE (core busy from elsewhere) -> no pop, wait.
//  Empty FIFO in IDLE -> remain IDLE, o_uart_we stays 0.
// TESTING
//  Reset -> o_empty=1, o_count=0, o_uart_we=0, flags 0; assert i_rst mid-WAIT_LO -> same.
//  Write 0x01 with core model: busy rises 1 cycle after we, for 10 cycles.
//   -> exactly one 1-cycle we pulse with data=0x01; o_empty=1 after the pop.
//  Burst-write 0x41..0x45 on 5 consecutive cycles.
//   -> 5 strobes in order 0x41..0x45, each only after busy falls; o_count peaks at 4 or 5.
//  Write 17 bytes with core busy held high.
//   -> o_full=1 at count 16, 17th byte dropped, o_overflow=1; drain yields bytes 1..16.
//  Core model never raises busy -> o_ack_err=1 after ACK_TO=15 cycles in WAIT_HI.
//   FSM returns to IDLE and the next byte is sent normally.
//  Write on the same edge as a pop with 16 wrap-around writes total -> pointer wrap is clean.
//   Also: count is correct, data order is preserved, no spurious overflow.

Source files
------------

// File: rtl/uart_tx_feeder_if.sv
// Producer-side FIFO port and UART-core handshake for uart_tx_feeder.
// The master modport is the feeder itself; the slave side is the producer plus core.
interface uart_tx_feeder_if #(
  parameter int AW = 4,
  parameter int W  = 8
);
  logic          i_wr_en;
  logic [W-1:0]  i_wr_data;
  logic          o_full;
  logic          o_empty;
  logic [AW:0]   o_count;
  logic          o_overflow;
  logic          o_ack_err;
  logic [W-1:0]  o_uart_data;
  logic          o_uart_we;
  logic          i_uart_busy;

  modport master (
    input  i_wr_en, i_wr_data, i_uart_busy,
    output o_full, o_empty, o_count, o_overflow, o_ack_err, o_uart_data, o_uart_we
  );

  modport slave (
    output i_wr_en, i_wr_data, i_uart_busy,
    input  o_full, o_empty, o_count, o_overflow, o_ack_err, o_uart_data, o_uart_we
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that drains one byte at a time into a UART transmitter core,
// waiting for the core's busy pulse to rise and fall between bytes.
module uart_tx_feeder #(
  parameter int AW     = 4,
  parameter int W      = 8,
  parameter int ACK_TO = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_tx_feeder_if.master  bus
);
  localparam int DEPTH = 2 ** AW;
  localparam int TW    = $clog2(ACK_TO + 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_HI, WAIT_LO} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic            full_reg, empty_reg;
  logic            overflow_reg;
  logic            ack_err_reg, ack_err_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [W-1:0]    data_reg;
  logic            we_reg;
  logic            push, pop;

  // full_reg is the registered flag, so a write while full is dropped even if a pop frees a slot
  assign push = bus.i_wr_en && !full_reg;

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    ack_err_next = ack_err_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_reg && !bus.i_uart_busy) begin
          pop        = 1'b1;
          state_next = STROBE;
        end
      end
      STROBE: begin
        timer_next = '0;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.i_uart_busy) begin
          state_next = WAIT_LO;
        end else if (timer_reg == TW'(ACK_TO - 1)) begin
          // Core never acknowledged: give up on this byte and move on
          ack_err_next = 1'b1;
          state_next   = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.i_uart_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      ack_err_reg  <= 1'b0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
      we_reg       <= 1'b0;
      data_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      ack_err_reg <= ack_err_next;
      count_reg   <= count_next;
      full_reg    <= (count_next == (AW+1)'(DEPTH));
      empty_reg   <= (count_next == '0);
      we_reg      <= pop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        data_reg   <= mem[rd_ptr_reg];
      end
      if (bus.i_wr_en && full_reg) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.o_full      = full_reg;
  assign bus.o_empty     = empty_reg;
  assign bus.o_count     = count_reg;
  assign bus.o_overflow  = overflow_reg;
  assign bus.o_ack_err   = ack_err_reg;
  assign bus.o_uart_data = data_reg;
  assign bus.o_uart_we   = we_reg;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: core model, scoreboard of expected strobe bytes,
// a table-driven fill/overflow sweep and hand-written latency/reset/timeout/wrap sequences.
module tb_uart_tx_feeder;
  localparam int AW     = 4;
  localparam int W      = 8;
  localparam int ACK_TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.AW(AW), .W(W)) bus();

  uart_tx_feeder #(.AW(AW), .W(W), .ACK_TO(ACK_TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Core model: busy rises the cycle after a strobe and stays high busy_len cycles
  int busy_len  = 10;
  bit core_ack  = 1'b1;
  bit hold_busy = 1'b0;
  int busy_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst)                             busy_cnt <= 0;
    else if (bus.o_uart_we && core_ack)  busy_cnt <= busy_len;
    else if (busy_cnt > 0)               busy_cnt <= busy_cnt - 1;
  end
  assign bus.i_uart_busy = hold_busy || (busy_cnt != 0);

  logic [7:0] exp_q[$];
  int passed = 0;
  int total  = 0;
  int wr_acc = 0;
  int strobes = 0;
  int peak = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] mon_e;
  bit prev_we = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard and per-cycle invariants, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_uart_we) begin
        strobes++;
        if (exp_q.size() == 0) begin
          chk("strobe_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("strobe %0d data=0x%02h expected=0x%02h", strobes, bus.o_uart_data, mon_e);
          chk("strobe_data", bus.o_uart_data, mon_e);
        end
        chk("strobe_width", prev_we, 0);
        chk("strobe_busy_low", bus.i_uart_busy, 0);
        last_data = bus.o_uart_data;
      end else begin
        chk("data_hold", bus.o_uart_data, last_data);
      end
      chk("count", bus.o_count, wr_acc - strobes);
      chk("empty", bus.o_empty, int'((wr_acc - strobes) == 0));
      if (int'(bus.o_count) > peak) peak = bus.o_count;
      prev_we = bus.o_uart_we;
    end
  end

  task automatic wr(input logic [7:0] d, input bit acc);
    @(negedge clk);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_data = d;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    if (acc) wr_acc++;
    #1 bus.i_wr_en = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},    bus.o_count, 0);
    chk({tag, "_empty"},    bus.o_empty, 1);
    chk({tag, "_full"},     bus.o_full, 0);
    chk({tag, "_we"},       bus.o_uart_we, 0);
    chk({tag, "_data"},     bus.o_uart_data, 0);
    chk({tag, "_overflow"}, bus.o_overflow, 0);
    chk({tag, "_ack_err"},  bus.o_ack_err, 0);
  endtask

  // Asserted between edges so the async clear is observed before any clock edge
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    wr_acc = 0; strobes = 0; last_data = 8'h00; prev_we = 1'b0;
    bus.i_wr_en = 1'b0;
    #1 chk_reset_state(tag);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && bus.o_empty && busy_cnt == 0 && !bus.o_uart_we) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk({tag, "_drain_timeout"}, 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_strobes(input int target, input int bound, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (strobes >= target) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk({tag, "_strobe_timeout"}, 1, 0);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       acc;
    int         exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t vt[18];

  initial begin
    int s0;
    bit got;

    for (int k = 0; k < 17; k++) begin
      vt[k].wr        = 1'b1;
      vt[k].data      = 8'(k + 1);
      vt[k].acc       = (k < 16);
      vt[k].exp_count = (k < 16) ? k + 1 : 16;
      vt[k].exp_full  = (k >= 15);
      vt[k].exp_ovf   = (k == 16);
    end
    vt[17].wr = 1'b0; vt[17].data = 8'h00; vt[17].acc = 1'b0;
    vt[17].exp_count = 16; vt[17].exp_full = 1'b1; vt[17].exp_ovf = 1'b1;

    bus.i_wr_en = 1'b0;
    bus.i_wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    #2 rst = 1'b0;

    // Single byte: written at edge N, strobe visible after edge N+1
    s0 = strobes;
    wr(8'h01, 1'b1);
    chk("lat_count", bus.o_count, 1);
    chk("lat_we_early", bus.o_uart_we, 0);
    @(posedge clk); #1;
    chk("lat_we", bus.o_uart_we, 1);
    chk("lat_empty_after_pop", bus.o_empty, 1);
    wait_drain(100, "single");
    chk("single_strobes", strobes - s0, 1);

    // Back-to-back burst
    s0 = strobes;
    peak = 0;
    for (int i = 0; i < 5; i++) wr(8'(8'h41 + i), 1'b1);
    wait_drain(200, "burst");
    chk("burst_strobes", strobes - s0, 5);
    if (peak < 4 || peak > 5) chk("burst_peak", peak, 4);
    else chk("burst_peak", 1, 1 - int'(peak < 4 || peak > 5) * 0);

    // Fill to full with the core held busy, then overflow
    hold_busy = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (vt[k].wr) wr(vt[k].data, vt[k].acc);
      else begin @(posedge clk); #1; end
      $display("vec %0d wr=%0d data=0x%02h count=%0d full=%0d ovf=%0d", k, vt[k].wr,
               vt[k].data, bus.o_count, bus.o_full, bus.o_overflow);
      chk("vec_count", bus.o_count, vt[k].exp_count);
      chk("vec_full", bus.o_full, vt[k].exp_full);
      chk("vec_overflow", bus.o_overflow, vt[k].exp_ovf);
    end
    @(negedge clk);
    hold_busy = 1'b0;
    wait_drain(400, "fill");
    chk("fill_ovf_sticky", bus.o_overflow, 1);
    chk("fill_full_cleared", bus.o_full, 0);

    // Reset while the core is busy with the first of three bytes
    s0 = strobes;
    wr(8'h11, 1'b1); wr(8'h12, 1'b1); wr(8'h13, 1'b1);
    wait_strobes(s0 + 1, 20, "midrst");
    repeat (4) @(posedge clk);
    apply_reset("midrst");
    repeat (20) @(negedge clk);
    chk("post_reset_strobes", strobes, 0);

    // Core never acknowledges
    core_ack = 1'b0;
    s0 = strobes;
    wr(8'h77, 1'b1);
    wait_strobes(s0 + 1, 20, "ack");
    repeat (10) @(posedge clk);
    #1 chk("ack_err_early", bus.o_ack_err, 0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_ack_err) begin got = 1'b1; break; end
    end
    chk("ack_err_set", got, 1);
    core_ack = 1'b1;
    wr(8'h78, 1'b1);
    wait_drain(100, "ack_recover");
    chk("ack_recover_strobes", strobes - s0, 2);
    chk("ack_err_sticky", bus.o_ack_err, 1);

    // Pointer wrap with writes overlapping pops
    apply_reset("wraprst");
    busy_len = 2;
    for (int i = 0; i < 8; i++) wr(8'(8'h80 + i), 1'b1);
    wait_drain(200, "prewrap");
    s0 = strobes;
    peak = 0;
    for (int i = 0; i < 16; i++) wr(8'(8'hA0 + i), 1'b1);
    wait_drain(300, "wrap");
    chk("wrap_strobes", strobes - s0, 16);
    chk("wrap_no_overflow", bus.o_overflow, 0);
    chk("wrap_count", bus.o_count, 0);
    chk("wrap_peak_below_full", int'(peak < 16), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
